// File: rtl/spi_reg_ctrl.sv
// SPI frame controller: turns synchronised SPI edge strobes into register read/write requests.
// Define SPI_AUTOINC_EN for burst frames with an auto-incrementing address; default is one word per frame.
module spi_reg_ctrl (
  input  logic        clk,
  input  logic        nrst,
  input  logic        spi_start,
  input  logic        spi_sck_rising,
  input  logic        spi_sck_falling,
  input  logic        spi_busy,
  input  logic        mosi,
  output logic        miso,
  output logic [6:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  input  logic        reg_rack,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, RD_WAIT, DATA} state_t;

  localparam logic [4:0] CMD_LAST  = 5'd7;
  localparam logic [4:0] DATA_LAST = 5'd15;
  localparam logic [4:0] WORD_DONE = 5'd16;

  state_t      state_reg;
  logic [4:0]  bit_cnt_reg;
  logic [14:0] rx_shift_reg;
  logic [15:0] tx_shift_reg;
  logic        rd_flag_reg;
  logic        busy_d_reg;
  logic        miso_reg;
  logic [6:0]  reg_addr_reg;
  logic [15:0] reg_wdata_reg;
  logic        reg_we_reg;
  logic        reg_re_reg;
  logic        frame_err_reg;

  logic [15:0] rx_word;
  logic        busy_fall;
  logic        frame_partial;

  assign rx_word   = {rx_shift_reg, mosi};
  assign busy_fall = busy_d_reg & ~spi_busy;

  // Ending on a word boundary (or on the single-word done count) is clean
  always_comb begin
    frame_partial = 1'b0;
    case (state_reg)
      CMD:     frame_partial = (bit_cnt_reg != 5'd0);
      DATA:    frame_partial = (bit_cnt_reg != 5'd0) && (bit_cnt_reg != WORD_DONE);
      default: frame_partial = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 5'd0;
      rx_shift_reg  <= 15'd0;
      tx_shift_reg  <= 16'd0;
      rd_flag_reg   <= 1'b0;
      busy_d_reg    <= 1'b0;
      miso_reg      <= 1'b0;
      reg_addr_reg  <= 7'd0;
      reg_wdata_reg <= 16'd0;
      reg_we_reg    <= 1'b0;
      reg_re_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      busy_d_reg    <= spi_busy;
      reg_we_reg    <= 1'b0;
      reg_re_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef SPI_AUTOINC_EN
      // Write bursts step the address only after the strobe has used it
      if (reg_we_reg) begin
        reg_addr_reg <= reg_addr_reg + 7'd1;
      end
`endif
      if (spi_start) begin
        state_reg    <= CMD;
        bit_cnt_reg  <= 5'd0;
        rx_shift_reg <= 15'd0;
        tx_shift_reg <= 16'd0;
        rd_flag_reg  <= 1'b0;
        miso_reg     <= 1'b0;
      end else if (busy_fall) begin
        state_reg <= IDLE;
        miso_reg  <= 1'b0;
        if (frame_partial) begin
          frame_err_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            miso_reg <= 1'b0;
          end

          CMD: begin
            miso_reg <= 1'b0;
            if (spi_sck_rising) begin
              if (bit_cnt_reg == CMD_LAST) begin
                reg_addr_reg <= rx_word[6:0];
                rd_flag_reg  <= rx_word[7];
                bit_cnt_reg  <= 5'd0;
                rx_shift_reg <= 15'd0;
                if (rx_word[7]) begin
                  reg_re_reg <= 1'b1;
                  state_reg  <= RD_WAIT;
                end else begin
                  state_reg  <= DATA;
                end
              end else begin
                rx_shift_reg <= rx_word[14:0];
                bit_cnt_reg  <= bit_cnt_reg + 5'd1;
              end
            end
          end

          RD_WAIT: begin
            miso_reg <= 1'b0;
            if (reg_rack) begin
              state_reg <= DATA;
              // Data arriving on the same cycle as the falling strobe is still on time
              if (spi_sck_falling) begin
                miso_reg     <= reg_rdata[15];
                tx_shift_reg <= {reg_rdata[14:0], 1'b0};
              end else begin
                tx_shift_reg <= reg_rdata;
              end
            end else if (spi_sck_falling) begin
              frame_err_reg <= 1'b1;
              tx_shift_reg  <= 16'd0;
              state_reg     <= DATA;
            end
          end

          DATA: begin
            if (bit_cnt_reg != WORD_DONE) begin
              if (spi_sck_rising) begin
                rx_shift_reg <= rx_word[14:0];
                if (bit_cnt_reg == DATA_LAST) begin
                  if (!rd_flag_reg) begin
                    reg_we_reg    <= 1'b1;
                    reg_wdata_reg <= rx_word;
                  end
`ifdef SPI_AUTOINC_EN
                  bit_cnt_reg <= 5'd0;
                  if (rd_flag_reg) begin
                    reg_addr_reg <= reg_addr_reg + 7'd1;
                    reg_re_reg   <= 1'b1;
                    state_reg    <= RD_WAIT;
                  end
`else
                  bit_cnt_reg <= WORD_DONE;
`endif
                end else begin
                  bit_cnt_reg <= bit_cnt_reg + 5'd1;
                end
              end
              // Each falling strobe presents the next bit, MSB first
              if (spi_sck_falling && rd_flag_reg) begin
                miso_reg     <= tx_shift_reg[15];
                tx_shift_reg <= {tx_shift_reg[14:0], 1'b0};
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign miso      = miso_reg;
  assign reg_addr  = reg_addr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign reg_we    = reg_we_reg;
  assign reg_re    = reg_re_reg;
  assign frame_err = frame_err_reg;

endmodule
